sorter_share_arbiter: RTL
=========================

Name: sorter_share_arbiter

Overview:
- Shares one pipelined mWideSorter instance between R requesters.
- Each requester presents an M-wide vector of N-bit values with a valid/ready handshake.
- Grants are round-robin, one vector per cycle; the block tracks each vector through the sorter's fixed latency and returns the sorted vector tagged with the originating requester ID.
- A Flush/FlushDone sequence drains the sorter before reconfiguration or power-down.

Parameters:
N, 4, width of each element in bits
M, 4, number of elements per vector
R, 2, number of requesters (R >= 1)
LAT, 2, sorter latency in cycles from SortX change to matching SortY (LAT >= 0)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
ReqValid  in  R  per-requester vector valid
ReqReady  out  R  per-requester grant; at most one bit high
ReqX  in  R*M*N  requester r's vector at bits [r*M*N +: M*N]; element i at [i*N +: N]
SortX  out  M*N  registered vector driven to sorter X
SortY  in  M*N  sorter Y
RspValid  out  1  sorted vector available this cycle
RspId  out  max(1,clog2(R))  requester index owning RspY
RspY  out  M*N  sorted vector; combinational pass-through of SortY
Flush  in  1  request drain
FlushDone  out  1  drained, no grants outstanding
Idle  out  1  no vectors in flight

Behaviour:
- Reset state:
  - state=RUN, RrPtr=0, all tag valids 0.
  - SortX=0, RspValid=0, RspId=0, FlushDone=0, Idle=1.
- Reset mid-operation discards all in-flight vectors; no RspValid follows. The same Reset drives the sorter.
- States:
  - RUN: grants allowed.
  - DRAIN: ReqReady=0; waiting for tag pipe empty.
  - DONE: ReqReady=0, FlushDone=1.
- Transitions:
  - RUN->DRAIN when Flush=1 (a grant in that same cycle is still honoured).
  - DRAIN->DONE on the first cycle the tag pipe is empty, evaluated after that cycle's shift.
  - DONE->RUN when Flush=0.
  - Flush dropping during DRAIN does not abort the drain.
- Arbitration (RUN only), combinational:
  - g = first index at or after RrPtr, wrapping, with ReqValid[g]=1.
  - ReqReady[g]=1, all other bits 0. No valid requester means no grant.
  - Requesters must hold ReqX stable while ReqValid=1 and ReqReady=0.
  - On a fire (ReqValid[g] & ReqReady[g]): RrPtr <= (g+1) mod R.
  - With no fire, RrPtr holds.
- Issue:
  - On fire: SortX <= ReqX slice g.
  - With no fire, SortX holds its previous value. Its tag is a bubble (valid 0), so any sorter output for it is ignored.
- Tag pipe:
  - LAT+1 entries of {valid, id}, shifting every cycle; entry 0 is loaded {fire, g}.
  - Output entry drives RspValid and RspId.
- Latency: handshake in cycle t gives RspValid=1 in cycle t+1+LAT. Throughput is one vector per cycle.
- Back-to-back grants produce back-to-back responses in grant order.
- No response backpressure: the consumer must accept any cycle RspValid=1.
- RspY is don't-care when RspValid=0.
- Idle=1 iff all tag valids are 0.
- R=1: RrPtr stays 0 and RspId=0.

Optional Feature:
- Macro: SORTER_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output GrantCnt, R*16 bits, one counter per requester at [r*16 +: 16].
  - Each counter increments on that requester's fire and saturates at 16'hFFFF.
  - Counters clear on Reset or when Flush is high in DONE.
- When undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request:
  - Stimulus: LAT=2; R0 presents elements {8,6,1,2} for one cycle.
  - Required: ReqReady[0]=1 same cycle. SortX equals that vector the next cycle. RspValid=1 with RspId=0 exactly 3 cycles after the handshake. RspY equals the sorter model output for {8,6,1,2}.
- Fairness:
  - Stimulus: R0 and R1 both hold ReqValid=1 for 6 cycles with distinct vectors.
  - Required: grants 0,1,0,1,0,1. Six back-to-back responses with RspId 0,1,0,1,0,1, each carrying that requester's sorted vector.
- Pointer skip:
  - Stimulus: RrPtr=0, only ReqValid[1]=1.
  - Required: ReqReady=2'b10 immediately; RrPtr becomes 0 afterwards.
- Flush drain:
  - Stimulus: 3 vectors in flight; Flush=1 while ReqValid stays high.
  - Required: ReqReady=0 from the next cycle. Exactly 3 responses appear. FlushDone=1 on the cycle after the last RspValid, with Idle=1. Dropping Flush returns to RUN and grants resume the next cycle.
- Reset mid-flight:
  - Stimulus: 2 vectors in flight; Reset=1 for 1 cycle.
  - Required: no RspValid afterwards, SortX=0, RrPtr=0, Idle=1.
- Stats (SORTER_SHARE_ARB_STATS_EN):
  - Stimulus: the fairness scenario.
  - Required: GrantCnt = {16'd3, 16'd3}. A counter forced to 16'hFFFF stays at 16'hFFFF on its next grant.

Source files
------------

// File: rtl/sorter_share_arbiter.sv
// rtl/sorter_share_arbiter.sv - round-robin share of one pipelined sorter among R requesters
// Optional per-requester grant counters: define SORTER_SHARE_ARB_STATS_EN.

module sorter_share_arbiter #(
   parameter int N   = 4,
   parameter int M   = 4,
   parameter int R   = 2,
   parameter int LAT = 2,
   localparam int IW = (R > 1) ? $clog2(R) : 1,
   localparam int VW = M * N
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [R-1:0]    ReqValid,
   output logic [R-1:0]    ReqReady,
   input  logic [R*VW-1:0] ReqX,
   output logic [VW-1:0]   SortX,
   input  logic [VW-1:0]   SortY,
   output logic            RspValid,
   output logic [IW-1:0]   RspId,
   output logic [VW-1:0]   RspY,
   input  logic            Flush,
   output logic            FlushDone,
   output logic            Idle
`ifdef SORTER_SHARE_ARB_STATS_EN
   ,
   output logic [R*16-1:0] GrantCnt
`endif
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   localparam logic [IW:0] R_W = (IW+1)'(R);

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic [VW-1:0]   grant_x;
   logic            fire;
   logic            pipe_busy_nxt;
   logic            tag_valid [LAT+1];
   logic [IW-1:0]   tag_id    [LAT+1];

   always_comb begin : arbitrate
      logic [IW:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_x     = '0;
      cand        = '0;
      for (int k = 0; k < R; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= R_W) cand = cand - R_W;
         if (!grant_found && ReqValid[cand[IW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IW-1:0];
         end
      end
      for (int r = 0; r < R; r++) begin
         if (grant_idx == IW'(r)) grant_x = ReqX[r*VW +: VW];
      end
   end

   assign fire = (state == RUN) && grant_found;

   always_comb begin
      state_nxt     = state;
      ReqReady      = '0;
      FlushDone     = 1'b0;
      // occupancy of the tag pipe as it will be after this cycle's shift
      pipe_busy_nxt = fire;
      for (int i = 0; i < LAT; i++) begin
         if (tag_valid[i]) pipe_busy_nxt = 1'b1;
      end
      case (state)
         RUN: begin
            if (grant_found) ReqReady[grant_idx] = 1'b1;
            if (Flush) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!pipe_busy_nxt) state_nxt = DONE;
         end
         DONE: begin
            FlushDone = 1'b1;
            if (!Flush) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= RUN;
         rr_ptr <= '0;
         SortX  <= '0;
         for (int i = 0; i <= LAT; i++) begin
            tag_valid[i] <= 1'b0;
            tag_id[i]    <= '0;
         end
      end else begin
         state <= state_nxt;
         if (fire) begin
            rr_ptr <= (grant_idx == IW'(R-1)) ? '0 : grant_idx + 1'b1;
            SortX  <= grant_x;
         end
         tag_valid[0] <= fire;
         tag_id[0]    <= grant_idx;
         for (int i = 1; i <= LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
         end
      end
   end

   assign RspValid = tag_valid[LAT];
   assign RspId    = tag_id[LAT];
   assign RspY     = SortY;

   always_comb begin
      Idle = 1'b1;
      for (int i = 0; i <= LAT; i++) begin
         if (tag_valid[i]) Idle = 1'b0;
      end
   end

`ifdef SORTER_SHARE_ARB_STATS_EN
   logic [15:0] grant_cnt [R];

   always_ff @(posedge Clk) begin
      for (int r = 0; r < R; r++) begin
         if (Reset || (state == DONE && Flush)) begin
            grant_cnt[r] <= '0;
         end else if (fire && grant_idx == IW'(r) && grant_cnt[r] != 16'hFFFF) begin
            grant_cnt[r] <= grant_cnt[r] + 16'd1;
         end
      end
   end

   for (genvar r = 0; r < R; r++) begin : g_cnt_out
      assign GrantCnt[r*16 +: 16] = grant_cnt[r];
   end
`endif

endmodule
